// File: rtl/fir_mac_sequencer_pkg.sv
// Shared types and sizing for the time-multiplexed FIR sequencer.
// Optional result counter is enabled by defining FIR_SEQ_PERF_CNT_EN.
package fir_seq_pkg;

    localparam int TAPS      = 10;
    localparam int DW        = 4;
    localparam int CW        = 4;
    localparam int OW        = 12;
    localparam int TAP_IDX_W = $clog2(TAPS);
    localparam int ADDR_W    = 4;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Sample, coefficient and result handshakes of the FIR sequencer.
// result_count exists only when FIR_SEQ_PERF_CNT_EN is defined.
interface fir_mac_sequencer_if;

    logic                        in_valid;
    logic                        in_ready;
    logic [fir_seq_pkg::DW-1:0]  in_data;
    logic                        coef_we;
    logic [fir_seq_pkg::ADDR_W-1:0] coef_addr;
    logic [fir_seq_pkg::CW-1:0]  coef_data;
    logic                        coef_ready;
    logic                        out_valid;
    logic                        out_ready;
    logic [fir_seq_pkg::OW-1:0]  out_data;
    logic                        busy;
`ifdef FIR_SEQ_PERF_CNT_EN
    logic [fir_seq_pkg::CNT_W-1:0] result_count;

    modport slave (
        input  in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
        output in_ready, coef_ready, out_valid, out_data, busy, result_count
    );
    modport master (
        output in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
        input  in_ready, coef_ready, out_valid, out_data, busy, result_count
    );
`else
    modport slave (
        input  in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
        output in_ready, coef_ready, out_valid, out_data, busy
    );
    modport master (
        output in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
        input  in_ready, coef_ready, out_valid, out_data, busy
    );
`endif

endinterface

// File: rtl/fir_mac_sequencer_mac_unit.sv
// Registered multiply-accumulate: clear wins over enable, product zero-extended.
module fir_mac_unit #(
    parameter int DW = 4,
    parameter int CW = 4,
    parameter int OW = 12
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] x,
    input  logic [CW-1:0] h,
    output logic [OW-1:0] acc
);

    logic [DW+CW-1:0] prod;

    assign prod = x * h;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + {{(OW-DW-CW){1'b0}}, prod};
        end
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Ten-tap FIR built on one MAC: accept a sample, run TAPS accumulate steps, hold result.
// Define FIR_SEQ_PERF_CNT_EN to add a saturating count of delivered results.
module fir_mac_sequencer
    import fir_seq_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    fir_mac_sequencer_if.slave bus
);

    state_t                      state, state_nxt;
    logic [TAPS-1:0][DW-1:0]     x;
    logic [TAPS-1:0][CW-1:0]     h;
    logic [TAP_IDX_W-1:0]        tap;
    logic [OW-1:0]               acc;
    logic                        in_ready, coef_ready, out_valid;
    logic                        accept, coef_wr, mac_clr, mac_en;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        coef_ready = 1'b0;
        out_valid  = 1'b0;
        mac_clr    = 1'b0;
        mac_en     = 1'b0;
        case (state)
            IDLE: begin
                in_ready   = 1'b1;
                coef_ready = 1'b1;
                if (bus.in_valid) begin
                    mac_clr   = 1'b1;
                    state_nxt = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (tap == TAP_IDX_W'(TAPS-1)) state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept  = bus.in_valid & in_ready;
    // Writes outside IDLE are dropped, and out-of-range indices never touch the file.
    assign coef_wr = bus.coef_we & coef_ready & (bus.coef_addr < ADDR_W'(TAPS));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x <= '0;
        end else if (accept) begin
            x <= {x[TAPS-2:0], bus.in_data};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            h <= '0;
        end else if (coef_wr) begin
            h[bus.coef_addr[TAP_IDX_W-1:0]] <= bus.coef_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tap <= '0;
        end else if (accept) begin
            tap <= '0;
        end else if (mac_en) begin
            tap <= tap + TAP_IDX_W'(1);
        end
    end

    fir_mac_unit #(
        .DW (DW),
        .CW (CW),
        .OW (OW)
    ) u_mac (
        .clock (clock),
        .reset (reset),
        .clr   (mac_clr),
        .en    (mac_en),
        .x     (x[tap]),
        .h     (h[tap]),
        .acc   (acc)
    );

    assign bus.in_ready   = in_ready;
    assign bus.coef_ready = coef_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_data   = acc;
    assign bus.busy       = (state != IDLE);

`ifdef FIR_SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] result_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            result_count <= '0;
        end else if (out_valid && bus.out_ready && (result_count != {CNT_W{1'b1}})) begin
            result_count <= result_count + CNT_W'(1);
        end
    end

    assign bus.result_count = result_count;
`endif

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer: vector table plus multi-cycle corner sequences.
module tb_fir_mac_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;

    fir_mac_sequencer_if bus();

    fir_mac_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          grp;
        logic [3:0]  din;
        logic [11:0] exp;
    } vec_t;

    vec_t vec[$];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic write_coef(input logic [3:0] a, input logic [3:0] d);
        bus.coef_we   = 1'b1;
        bus.coef_addr = a;
        bus.coef_data = d;
        tick();
        bus.coef_we   = 1'b0;
    endtask

    task automatic setup(input int grp);
        do_reset();
        for (int k = 0; k < 10; k++) begin
            if (grp == 1)      write_coef(4'(k), 4'(k));
            else if (grp == 2) write_coef(4'(k), 4'd15);
            else               write_coef(4'(k), 4'd1);
        end
    endtask

    // Edges from the accepting edge until out_valid is seen, bounded at 20.
    task automatic wait_out(output int n);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic send(input logic [3:0] d, input logic [11:0] exp, input string name);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        chk({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        wait_out(n);
        chk({name, "_latency"}, 32'(n), 32'd10);
        chk({name, "_data"}, 32'(bus.out_data), 32'(exp));
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int prev_grp;
        bit stale;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        bus.out_ready = 1'b1;

        for (int i = 0; i < 11; i++) vec.push_back('{0, 4'd1, 12'((i < 10) ? i + 1 : 10)});
        for (int i = 0; i < 10; i++) vec.push_back('{1, (i == 0) ? 4'd1 : 4'd0, 12'(i)});
        for (int i = 0; i < 10; i++) vec.push_back('{2, 4'd15, 12'(225 * (i + 1))});

        #2;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_coef_ready", 32'(bus.coef_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
`ifdef FIR_SEQ_PERF_CNT_EN
        chk("rst_count", 32'(bus.result_count), 32'd0);
`endif

        prev_grp = -1;
        foreach (vec[i]) begin
            if (vec[i].grp != prev_grp) begin
                setup(vec[i].grp);
                prev_grp = vec[i].grp;
            end
            send(vec[i].din, vec[i].exp, $sformatf("vec%0d", i));
        end

        // Backpressure: result held, pending sample waits for the output handshake.
        setup(0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 4'd5;
        tick();
        bus.in_data   = 4'd3;
        wait_out(n);
        chk("bp_latency", 32'(n), 32'd10);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_out_data", 32'(bus.out_data), 32'd5);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp_idle_busy", 32'(bus.busy), 32'd0);
        chk("bp_idle_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_accept_busy", 32'(bus.busy), 32'd1);
        wait_out(n);
        chk("bp_second_data", 32'(bus.out_data), 32'd8);
        tick();

        // Coefficient gating against a delay line pre-filled with ones.
        setup(0);
        for (int i = 0; i < 4; i++) send(4'd1, 12'(i + 1), $sformatf("cg_fill%0d", i));
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd1;
        tick();
        bus.in_valid  = 1'b0;
        bus.coef_we   = 1'b1;
        bus.coef_addr = 4'd3;
        bus.coef_data = 4'd7;
        chk("cg_mac_coef_ready", 32'(bus.coef_ready), 32'd0);
        tick();
        tick();
        bus.coef_we = 1'b0;
        wait_out(n);
        chk("cg_dropped_data", 32'(bus.out_data), 32'd5);
        tick();
        bus.coef_we   = 1'b1;
        bus.coef_addr = 4'd3;
        bus.coef_data = 4'd7;
        bus.in_valid  = 1'b1;
        bus.in_data   = 4'd1;
        chk("cg_idle_coef_ready", 32'(bus.coef_ready), 32'd1);
        tick();
        bus.coef_we  = 1'b0;
        bus.in_valid = 1'b0;
        wait_out(n);
        chk("cg_coincident_data", 32'(bus.out_data), 32'd12);
        tick();
        write_coef(4'd12, 4'd15);
        send(4'd1, 12'd13, "cg_addr12");

        // Reset in the middle of accumulation.
        setup(0);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd1;
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        chk("mid_busy_before", 32'(bus.busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_out_data", 32'(bus.out_data), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_coef_ready", 32'(bus.coef_ready), 32'd1);
        tick();
        reset = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.out_valid) stale = 1'b1;
        end
        chk("mid_no_stale_valid", 32'(stale), 32'd0);
`ifdef FIR_SEQ_PERF_CNT_EN
        chk("mid_count_cleared", 32'(bus.result_count), 32'd0);
`endif
        send(4'd1, 12'd0, "mid_fresh");
`ifdef FIR_SEQ_PERF_CNT_EN
        chk("count_one", 32'(bus.result_count), 32'd1);
        send(4'd1, 12'd0, "mid_fresh2");
        chk("count_two", 32'(bus.result_count), 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
